iq_age_select: RTL and testbench



---
 rtl/iq_age_select.sv | 184 ++++++++++++++++++
 tb/tb_iq_age_select.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_age_select.sv
// Out-of-order issue queue: age-matrix oldest-first select, multi-port wakeup
// with dispatch bypass, FU backpressure, flush and a registered occupancy count.

module iq_age_select_match #(
  parameter int WAKE_W = 2,
  parameter int PREG_W = 8
) (
  input  logic [PREG_W-1:0]        tag_i,
  input  logic [WAKE_W-1:0]        wake_valid_i,
  input  logic [WAKE_W*PREG_W-1:0] wake_preg_i,
  output logic                     hit_o
);
  always_comb begin
    hit_o = 1'b0;
    for (int w = 0; w < WAKE_W; w++)
      if (wake_valid_i[w] && wake_preg_i[w*PREG_W +: PREG_W] == tag_i) hit_o = 1'b1;
  end
endmodule

module iq_age_select #(
  parameter int DEPTH      = 32,
  parameter int DISPATCH_W = 4,
  parameter int ISSUE_W    = 4,
  parameter int WAKE_W     = 2,
  parameter int ROB_W      = 7,
  parameter int PREG_W     = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DISPATCH_W-1:0]          disp_valid,
  input  logic [DISPATCH_W*ROB_W-1:0]    disp_rob,
  input  logic [DISPATCH_W*PREG_W-1:0]   disp_src1,
  input  logic [DISPATCH_W*PREG_W-1:0]   disp_src2,
  input  logic [DISPATCH_W-1:0]          disp_rdy1,
  input  logic [DISPATCH_W-1:0]          disp_rdy2,
  output logic                           disp_ready,
  input  logic [WAKE_W-1:0]              wake_valid,
  input  logic [WAKE_W*PREG_W-1:0]       wake_preg,
  input  logic                           issue_en,
  input  logic                           flush,
  output logic [ISSUE_W-1:0]             issue_valid,
  output logic [ISSUE_W*ROB_W-1:0]       issue_rob,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;
  localparam logic [CW-1:0] DISP_LIM = CW'(DEPTH - DISPATCH_W);

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] src1;
    logic              rdy1;
    logic [PREG_W-1:0] src2;
    logic              rdy2;
  } entry_t;

  logic [DEPTH-1:0]              valid_q, valid_d;
  entry_t [DEPTH-1:0]            ent_q, ent_d;
  logic [DEPTH-1:0][DEPTH-1:0]   older_q, older_d;
  logic [CW-1:0]                 count_q, count_d;

  logic [DEPTH-1:0]              hit1, hit2;
  logic [DISPATCH_W-1:0]         dhit1, dhit2;
  logic                          accept, found, got, blocked;
  logic [DISPATCH_W-1:0]         acc_lanes;
  logic [DEPTH-1:0]              alloc_v, cand, rem, issued;
  logic [DEPTH-1:0][LW-1:0]      alloc_ln;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      iq_age_select_match #(.WAKE_W(WAKE_W), .PREG_W(PREG_W)) u_m1 (
        .tag_i(ent_q[g].src1), .wake_valid_i(wake_valid), .wake_preg_i(wake_preg), .hit_o(hit1[g]));
      iq_age_select_match #(.WAKE_W(WAKE_W), .PREG_W(PREG_W)) u_m2 (
        .tag_i(ent_q[g].src2), .wake_valid_i(wake_valid), .wake_preg_i(wake_preg), .hit_o(hit2[g]));
    end
    for (g = 0; g < DISPATCH_W; g++) begin : g_disp
      iq_age_select_match #(.WAKE_W(WAKE_W), .PREG_W(PREG_W)) u_d1 (
        .tag_i(disp_src1[g*PREG_W +: PREG_W]), .wake_valid_i(wake_valid), .wake_preg_i(wake_preg),
        .hit_o(dhit1[g]));
      iq_age_select_match #(.WAKE_W(WAKE_W), .PREG_W(PREG_W)) u_d2 (
        .tag_i(disp_src2[g*PREG_W +: PREG_W]), .wake_valid_i(wake_valid), .wake_preg_i(wake_preg),
        .hit_o(dhit2[g]));
    end
  endgenerate

  // Space check uses registered count only, so same-cycle issues never free room.
  assign disp_ready = (count_q <= DISP_LIM);
  assign full       = (count_q == CW'(DEPTH));
  assign count      = count_q;
  assign accept     = disp_ready & ~flush;
  assign acc_lanes  = accept ? disp_valid : '0;

  // k-th valid lane takes the k-th lowest free entry
  always_comb begin
    alloc_v  = '0;
    alloc_ln = '0;
    found    = 1'b0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      found = 1'b0;
      if (acc_lanes[k])
        for (int i = 0; i < DEPTH; i++)
          if (!found && !valid_q[i] && !alloc_v[i]) begin
            alloc_v[i]  = 1'b1;
            alloc_ln[i] = LW'(k);
            found       = 1'b1;
          end
    end
  end

  // Oldest-first select: a candidate wins when no remaining candidate is older.
  assign cand = valid_q & {DEPTH{1'b1}} & ~'0;
  always_comb begin
    rem         = valid_q;
    issued      = '0;
    issue_valid = '0;
    issue_rob   = '0;
    got         = 1'b0;
    blocked     = 1'b0;
    for (int i = 0; i < DEPTH; i++) rem[i] = valid_q[i] & ent_q[i].rdy1 & ent_q[i].rdy2;
    if (issue_en && !flush) begin
      for (int l = 0; l < ISSUE_W; l++) begin
        got = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          blocked = 1'b0;
          for (int j = 0; j < DEPTH; j++)
            if (rem[j] && older_q[j][i]) blocked = 1'b1;
          if (rem[i] && !blocked && !got) begin
            got                          = 1'b1;
            issue_valid[l]               = 1'b1;
            issue_rob[l*ROB_W +: ROB_W]  = ent_q[i].rob;
            issued[i]                    = 1'b1;
          end
        end
        rem = rem & ~issued;
      end
    end
  end

  always_comb begin
    valid_d = (valid_q & ~issued) | alloc_v;
    ent_d   = ent_q;
    older_d = older_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i].rdy1 = ent_q[i].rdy1 | hit1[i];
      ent_d[i].rdy2 = ent_q[i].rdy2 | hit2[i];
    end
    for (int k = 0; k < DISPATCH_W; k++)
      for (int i = 0; i < DEPTH; i++)
        if (alloc_v[i] && alloc_ln[i] == LW'(k)) begin
          ent_d[i].rob  = disp_rob[k*ROB_W +: ROB_W];
          ent_d[i].src1 = disp_src1[k*PREG_W +: PREG_W];
          ent_d[i].src2 = disp_src2[k*PREG_W +: PREG_W];
          ent_d[i].rdy1 = disp_rdy1[k] | dhit1[k];
          ent_d[i].rdy2 = disp_rdy2[k] | dhit2[k];
        end
    // New entries are younger than residents; within a group lower lanes are older.
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++) begin
        if (alloc_v[i] && alloc_v[j]) older_d[i][j] = (alloc_ln[i] < alloc_ln[j]);
        else if (alloc_v[i])          older_d[i][j] = 1'b0;
        else if (alloc_v[j])          older_d[i][j] = 1'b1;
      end
    count_d = count_q + CW'($countones(acc_lanes)) - CW'($countones(issued));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      ent_q   <= '0;
      older_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
      older_q <= older_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_iq_age_select.sv
// Bench for iq_age_select: directed scenarios plus randomized traffic against an
// age-ordered queue model of the issue queue.

module tb_iq_age_select;
  localparam int DP = 32, DW = 4, IW = 4, WW = 2, RW = 7, PW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   disp_valid, disp_rdy1, disp_rdy2;
  logic [DW*RW-1:0] disp_rob;
  logic [DW*PW-1:0] disp_src1, disp_src2;
  logic            disp_ready;
  logic [WW-1:0]   wake_valid;
  logic [WW*PW-1:0] wake_preg;
  logic            issue_en, flush;
  logic [IW-1:0]   issue_valid;
  logic [IW*RW-1:0] issue_rob;
  logic [5:0]      count;
  logic            full;

  int n_vec = 0;
  int n_err = 0;

  iq_age_select #(.DEPTH(DP), .DISPATCH_W(DW), .ISSUE_W(IW), .WAKE_W(WW), .ROB_W(RW), .PREG_W(PW)) dut (
    .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_rob(disp_rob), .disp_src1(disp_src1),
    .disp_src2(disp_src2), .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2), .disp_ready(disp_ready),
    .wake_valid(wake_valid), .wake_preg(wake_preg), .issue_en(issue_en), .flush(flush),
    .issue_valid(issue_valid), .issue_rob(issue_rob), .count(count), .full(full));

  always #5 clk = ~clk;

  // Reference: entries kept oldest-first in a queue
  typedef struct { int rob; int s1; int s2; bit r1; bit r2; } ment_t;
  ment_t mq[$];
  logic [IW-1:0]    exp_iv;
  logic [IW*RW-1:0] exp_rob;

  function automatic bit woke(int tag);
    for (int w = 0; w < WW; w++)
      if (wake_valid[w] && int'(wake_preg[w*PW +: PW]) == tag) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_expect();
    int n = 0;
    exp_iv = '0; exp_rob = '0;
    if (issue_en && !flush)
      foreach (mq[i])
        if (n < IW && mq[i].r1 && mq[i].r2) begin
          exp_iv[n] = 1'b1; exp_rob[n*RW +: RW] = RW'(mq[i].rob); n++;
        end
  endtask

  task automatic model_update();
    ment_t keep[$];
    ment_t e;
    int n = 0;
    bit acc;
    if (!reset || flush) begin mq.delete(); return; end
    acc = (DP - mq.size()) >= DW;
    foreach (mq[i]) begin
      if (issue_en && n < IW && mq[i].r1 && mq[i].r2) n++;
      else keep.push_back(mq[i]);
    end
    foreach (keep[i]) begin
      if (woke(keep[i].s1)) keep[i].r1 = 1'b1;
      if (woke(keep[i].s2)) keep[i].r2 = 1'b1;
    end
    if (acc)
      for (int k = 0; k < DW; k++)
        if (disp_valid[k]) begin
          e.rob = int'(disp_rob[k*RW +: RW]);
          e.s1  = int'(disp_src1[k*PW +: PW]);
          e.s2  = int'(disp_src2[k*PW +: PW]);
          e.r1  = disp_rdy1[k] | woke(e.s1);
          e.r2  = disp_rdy2[k] | woke(e.s2);
          keep.push_back(e);
        end
    mq = keep;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_in();
    disp_valid = '0; disp_rob = '0; disp_src1 = '0; disp_src2 = '0;
    disp_rdy1 = '0; disp_rdy2 = '0; wake_valid = '0; wake_preg = '0;
    issue_en = 1'b1; flush = 1'b0; reset = 1'b1;
  endtask

  task automatic set_lane(input int k, input int rob, input int s1, input int s2, input bit r1, input bit r2);
    disp_valid[k] = 1'b1;
    disp_rob[k*RW +: RW]  = RW'(rob);
    disp_src1[k*PW +: PW] = PW'(s1);
    disp_src2[k*PW +: PW] = PW'(s2);
    disp_rdy1[k] = r1;
    disp_rdy2[k] = r2;
  endtask

  task automatic set_wake(input int w, input int tag);
    wake_valid[w] = 1'b1;
    wake_preg[w*PW +: PW] = PW'(tag);
  endtask

  task automatic test_reset();
    clear_in(); reset = 1'b0;
    tick(); tick();
    #1;
    n_vec++; if (count !== 6'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
    n_vec++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL reset_disp_ready got %b want 1", disp_ready); end
    n_vec++; if (issue_valid !== 4'b0) begin n_err++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
    n_vec++; if (issue_rob !== '0) begin n_err++; $display("FAIL reset_issue_rob got %h want 0", issue_rob); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_in();
    for (int k = 0; k < 4; k++) set_lane(k, 10 + k, 1, 2, 1'b1, 1'b1);
    tick();
    clear_in(); #1;
    n_vec++; if (issue_valid !== 4'b1111) begin n_err++; $display("FAIL basic_iv got %b want 1111", issue_valid); end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (issue_rob[k*RW +: RW] !== RW'(10 + k)) begin
        n_err++; $display("FAIL basic_rob lane %0d got %0d want %0d", k, issue_rob[k*RW +: RW], 10 + k);
      end
    end
    n_vec++; if (count !== 6'd4) begin n_err++; $display("FAIL basic_count got %0d want 4", count); end
    tick(); #1;
    n_vec++; if (count !== 6'd0) begin n_err++; $display("FAIL basic_drain got %0d want 0", count); end
    n_vec++; if (issue_valid !== 4'b0) begin n_err++; $display("FAIL basic_idle got %b want 0", issue_valid); end
  endtask

  task automatic test_fill();
    for (int gi = 0; gi < 7; gi++) begin
      clear_in();
      for (int k = 0; k < 4; k++) set_lane(k, gi*4 + k, 200 + k, 210 + gi, 1'b0, 1'b0);
      tick();
    end
    clear_in(); #1;
    n_vec++; if (count !== 6'd28) begin n_err++; $display("FAIL fill_count28 got %0d want 28", count); end
    n_vec++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready28 got %b want 1", disp_ready); end
    for (int k = 0; k < 4; k++) set_lane(k, 28 + k, 200, 220, 1'b0, 1'b0);
    tick(); clear_in(); #1;
    n_vec++; if (count !== 6'd32) begin n_err++; $display("FAIL fill_count32 got %0d want 32", count); end
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full); end
    n_vec++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready32 got %b want 0", disp_ready); end
    for (int k = 0; k < 4; k++) set_lane(k, 100 + k, 1, 1, 1'b1, 1'b1);
    tick(); clear_in(); #1;
    n_vec++; if (count !== 6'd32) begin n_err++; $display("FAIL fill_ignored got %0d want 32", count); end
    n_vec++; if (issue_valid !== 4'b0) begin n_err++; $display("FAIL fill_no_issue got %b want 0", issue_valid); end
    flush = 1'b1;
    tick(); clear_in(); #1;
    n_vec++; if (count !== 6'd0 || full !== 1'b0) begin
      n_err++; $display("FAIL fill_flush count %0d full %b want 0 0", count, full);
    end
  endtask

  task automatic test_wake_order();
    clear_in();
    set_lane(0, 20, 5, 0, 1'b0, 1'b1);
    set_lane(1, 21, 9, 0, 1'b0, 1'b1);
    tick();
    clear_in(); set_wake(0, 9); #1;
    n_vec++; if (issue_valid !== 4'b0) begin n_err++; $display("FAIL wake_early got %b want 0", issue_valid); end
    tick();
    clear_in(); set_wake(1, 5); #1;
    n_vec++; if (issue_valid !== 4'b0001 || issue_rob[RW-1:0] !== 7'd21) begin
      n_err++; $display("FAIL wake_first iv %b rob %0d want 0001 21", issue_valid, issue_rob[RW-1:0]);
    end
    tick();
    clear_in(); #1;
    n_vec++; if (issue_valid !== 4'b0001 || issue_rob[RW-1:0] !== 7'd20) begin
      n_err++; $display("FAIL wake_second iv %b rob %0d want 0001 20", issue_valid, issue_rob[RW-1:0]);
    end
    tick(); #1;
    n_vec++; if (count !== 6'd0) begin n_err++; $display("FAIL wake_drain got %0d want 0", count); end
  endtask

  task automatic test_bypass();
    clear_in();
    set_lane(0, 30, 7, 3, 1'b0, 1'b1);
    set_wake(0, 7); #1;
    n_vec++; if (issue_valid !== 4'b0) begin n_err++; $display("FAIL bypass_same got %b want 0", issue_valid); end
    tick();
    clear_in(); #1;
    n_vec++; if (issue_valid !== 4'b0001 || issue_rob[RW-1:0] !== 7'd30) begin
      n_err++; $display("FAIL bypass_issue iv %b rob %0d want 0001 30", issue_valid, issue_rob[RW-1:0]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    clear_in(); issue_en = 1'b0;
    for (int k = 0; k < 4; k++) set_lane(k, 40 + k, 1, 1, 1'b1, 1'b1);
    tick();
    clear_in(); issue_en = 1'b0;
    set_lane(0, 44, 1, 1, 1'b1, 1'b1); set_lane(1, 45, 1, 1, 1'b1, 1'b1);
    tick();
    for (int c = 0; c < 2; c++) begin
      clear_in(); issue_en = 1'b0; set_wake(0, 77); #1;
      n_vec++; if (issue_valid !== 4'b0 || count !== 6'd6) begin
        n_err++; $display("FAIL bp_hold cyc %0d iv %b count %0d want 0 6", c, issue_valid, count);
      end
      tick();
    end
    clear_in(); #1;
    n_vec++; if (issue_valid !== 4'b1111 || issue_rob !== {7'd43, 7'd42, 7'd41, 7'd40}) begin
      n_err++; $display("FAIL bp_release iv %b rob %h", issue_valid, issue_rob);
    end
    tick(); #1;
    n_vec++; if (issue_valid !== 4'b0011 || issue_rob[2*RW-1:0] !== {7'd45, 7'd44} || count !== 6'd2) begin
      n_err++; $display("FAIL bp_rest iv %b rob %h count %0d want 0011 45/44 2", issue_valid, issue_rob, count);
    end
    tick();
  endtask

  task automatic test_flush();
    for (int gi = 0; gi < 3; gi++) begin
      clear_in(); issue_en = 1'b0;
      for (int k = 0; k < 4; k++)
        set_lane(k, 60 + gi*4 + k, 50 + gi*4 + k, 0, gi == 2, 1'b1);
      tick();
    end
    clear_in(); #1;
    n_vec++; if (count !== 6'd12) begin n_err++; $display("FAIL flush_pre got %0d want 12", count); end
    for (int k = 0; k < 4; k++) set_lane(k, 90 + k, 1, 1, 1'b1, 1'b1);
    flush = 1'b1; #1;
    n_vec++; if (issue_valid !== 4'b0 || issue_rob !== '0) begin
      n_err++; $display("FAIL flush_issue iv %b rob %h want 0", issue_valid, issue_rob);
    end
    tick();
    clear_in(); set_wake(0, 50); #1;
    n_vec++; if (count !== 6'd0 || disp_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_post count %0d ready %b want 0 1", count, disp_ready);
    end
    tick(); clear_in(); #1;
    n_vec++; if (issue_valid !== 4'b0 || count !== 6'd0) begin
      n_err++; $display("FAIL flush_stale iv %b count %0d want 0 0", issue_valid, count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      clear_in();
      for (int k = 0; k < DW; k++)
        if ($urandom_range(0, 1) == 1)
          set_lane(k, $urandom_range(0, 127), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      for (int w = 0; w < WW; w++)
        if ($urandom_range(0, 1) == 1) set_wake(w, $urandom_range(0, 15));
      issue_en = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 59) == 0);
      reset    = ($urandom_range(0, 99) != 0);
      model_expect();
      #1;
      n_vec++; if (issue_valid !== exp_iv) begin
        n_err++; $display("FAIL rnd_iv cyc %0d got %b want %b", c, issue_valid, exp_iv);
      end
      n_vec++; if (issue_rob !== exp_rob) begin
        n_err++; $display("FAIL rnd_rob cyc %0d got %h want %h", c, issue_rob, exp_rob);
      end
      n_vec++; if (int'(count) != mq.size()) begin
        n_err++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, count, mq.size());
      end
      n_vec++; if (full !== (mq.size() == DP)) begin
        n_err++; $display("FAIL rnd_full cyc %0d got %b want %b", c, full, mq.size() == DP);
      end
      n_vec++; if (disp_ready !== ((DP - mq.size()) >= DW)) begin
        n_err++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, disp_ready, (DP - mq.size()) >= DW);
      end
      tick();
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_wake_order();
    test_bypass();
    test_backpressure();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
